// File: rtl/sr_ff_en.sv
// sr_ff_en: bank of independent edge-triggered SR flip-flops with shared
// synchronous enable, synchronous active-high reset and a configurable
// S=R=1 response (SR_MODE: 0 hold, 1 set, 2 reset, 3 toggle, other = reset).
// Optional macro SRFF_SR_ERR_EN adds a sticky srff_err_o flag that records
// any enabled S=R=1 request.
module sr_ff_en #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          SR_MODE   = 2
) (
  input  logic             srff_clk,
  input  logic             srff_rst_b,
  input  logic             srff_en_i,
  input  logic [WIDTH-1:0] srff_S_i,
  input  logic [WIDTH-1:0] srff_R_i,
  output logic [WIDTH-1:0] srff_Q_o,
  output logic [WIDTH-1:0] srff_Qb_o
`ifdef SRFF_SR_ERR_EN
  ,
  output logic             srff_err_o
`endif
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;

  // Per-bit S/R decode; the enable and reset are applied in the register.
  always_comb begin
    q_next = q_r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({srff_S_i[i], srff_R_i[i]})
        2'b00: q_next[i] = q_r[i];
        2'b01: q_next[i] = 1'b0;
        2'b10: q_next[i] = 1'b1;
        default: begin
          case (SR_MODE)
            0:       q_next[i] = q_r[i];
            1:       q_next[i] = 1'b1;
            3:       q_next[i] = ~q_r[i];
            default: q_next[i] = 1'b0;
          endcase
        end
      endcase
    end
  end

  // State register: reset beats enable, enable gates the decoded update.
  always_ff @(posedge srff_clk) begin
    if (srff_rst_b) begin
      q_r <= RESET_VAL;
    end else if (srff_en_i) begin
      q_r <= q_next;
    end
  end

  assign srff_Q_o  = q_r;
  assign srff_Qb_o = ~q_r;

`ifdef SRFF_SR_ERR_EN
  logic err_r;

  // Sticky flag: any enabled bit seeing S=R=1 latches it until reset.
  always_ff @(posedge srff_clk) begin
    if (srff_rst_b) begin
      err_r <= 1'b0;
    end else if (srff_en_i && (|(srff_S_i & srff_R_i))) begin
      err_r <= 1'b1;
    end
  end

  assign srff_err_o = err_r;
`endif

endmodule

// File: tb/tb_sr_ff_en.sv
// tb_sr_ff_en: scoreboard bench. Four WIDTH=8 instances (SR_MODE 0..3,
// RESET_VAL 8'hA5) plus one default WIDTH=1 instance share the stimulus.
// The driver pushes model expectations; a monitor pops and compares.
module tb_sr_ff_en;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] s;
  logic [7:0] r;

  logic [7:0] q_a  [4];
  logic [7:0] qb_a [4];
  logic       w1_q;
  logic       w1_qb;
`ifdef SRFF_SR_ERR_EN
  logic       err_a [4];
  logic       w1_err;
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_mode
    sr_ff_en #(
      .WIDTH(8), .RESET_VAL(8'hA5), .SR_MODE(k)
    ) u_dut (
      .srff_clk   (clk),
      .srff_rst_b (rst),
      .srff_en_i  (en),
      .srff_S_i   (s),
      .srff_R_i   (r),
      .srff_Q_o   (q_a[k]),
      .srff_Qb_o  (qb_a[k])
`ifdef SRFF_SR_ERR_EN
      ,
      .srff_err_o (err_a[k])
`endif
    );
  end

  sr_ff_en u_w1 (
    .srff_clk   (clk),
    .srff_rst_b (rst),
    .srff_en_i  (en),
    .srff_S_i   (s[0]),
    .srff_R_i   (r[0]),
    .srff_Q_o   (w1_q),
    .srff_Qb_o  (w1_qb)
`ifdef SRFF_SR_ERR_EN
    ,
    .srff_err_o (w1_err)
`endif
  );

  typedef struct packed {
    logic [3:0][7:0] q;
    logic            w1;
    logic            err;
    logic            w1_err;
  } exp_t;

  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;

  // Reference state: what each flop bank should hold.
  logic [7:0] m_q [4];
  logic       m_w1;
  logic       m_err;
  logic       m_w1_err;

  // Behavioural rule for one bit given its S/R request and the mode.
  function automatic logic rule(logic cur, logic sb, logic rb, int mode);
    if (!sb && !rb) return cur;
    if (!sb &&  rb) return 1'b0;
    if ( sb && !rb) return 1'b1;
    if (mode == 0) return cur;
    if (mode == 1) return 1'b1;
    if (mode == 3) return ~cur;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one edge worth of stimulus and record the expected result.
  task automatic step(input logic rst_v, input logic en_v,
                      input logic [7:0] s_v, input logic [7:0] r_v);
    exp_t e;
    @(negedge clk);
    rst = rst_v; en = en_v; s = s_v; r = r_v;
    if (rst_v) begin
      for (int k = 0; k < 4; k++) m_q[k] = 8'hA5;
      m_w1 = 1'b0; m_err = 1'b0; m_w1_err = 1'b0;
    end else if (en_v) begin
      for (int k = 0; k < 4; k++)
        for (int b = 0; b < 8; b++)
          m_q[k][b] = rule(m_q[k][b], s_v[b], r_v[b], k);
      m_w1 = rule(m_w1, s_v[0], r_v[0], 2);
      if ((s_v & r_v) != 8'h00) m_err = 1'b1;
      if (s_v[0] && r_v[0]) m_w1_err = 1'b1;
    end
    for (int k = 0; k < 4; k++) e.q[k] = m_q[k];
    e.w1 = m_w1; e.err = m_err; e.w1_err = m_w1_err;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is checked after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("q_mode%0d", k),  q_a[k],  e.q[k]);
        chk($sformatf("qb_mode%0d", k), qb_a[k], ~e.q[k]);
`ifdef SRFF_SR_ERR_EN
        chk($sformatf("err_mode%0d", k), {7'd0, err_a[k]}, {7'd0, e.err});
`endif
      end
      chk("w1_q",  {7'd0, w1_q},  {7'd0, e.w1});
      chk("w1_qb", {7'd0, w1_qb}, {7'd0, ~e.w1});
`ifdef SRFF_SR_ERR_EN
      chk("w1_err", {7'd0, w1_err}, {7'd0, e.w1_err});
`endif
    end
  end

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; s = 8'h00; r = 8'h00;
    for (int k = 0; k < 4; k++) m_q[k] = 8'h00;
    m_w1 = 1'b0; m_err = 1'b0; m_w1_err = 1'b0;

    // Reset with S high, then enabled hold.
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    // Basic (S,R) sequence.
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    // Enable gating.
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    // Mode sweep from Q=1 with S=R=1 twice.
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    // Width pattern and reset overriding S.
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h0F, 8'hF0);
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    // Sticky error behaviour.
    step(1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(15) == 0), 1'($urandom), 8'($urandom), 8'($urandom));

    // Drain the scoreboard within a bounded number of edges.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
